// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch responder.
package ifetch_pkg;

    // Canonical RISC-V NOP (addi x0, x0, 0), substituted for out-of-range fetches.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        misaligned;
        logic        fault;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small response FIFO of fetch entries. DEPTH must be a power of two so the
// pointers wrap naturally; clear empties the FIFO without touching storage.
module fetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  fetch_entry_t i_data,
    input  logic         i_pop,
    input  logic         i_clear,
    output logic [CW-1:0] o_count,
    output fetch_entry_t o_head
);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Storage: only the slot under the write pointer changes on a push.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy; clear wins over any push/pop in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!i_push && i_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/ifetch_responder.sv
// Fetch-address responder: accepts one PC per cycle, reads a synchronous
// instruction memory and queues {pc, instr, flags} for the IF/ID register.
// Credits count buffered entries plus the one word still in the memory, so a
// request is only taken when its response is guaranteed a FIFO slot.
module ifetch_responder
    import ifetch_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int IMEM_WORDS = 1024,
    parameter int AW         = $clog2(IMEM_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [31:0]   req_pc,
    input  logic          flush,
    output logic          imem_en,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_rdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_pc,
    output logic [31:0]   rsp_instr,
    output logic          rsp_misaligned,
    output logic          rsp_fault
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] OCC_MAX = (CW + 1)'(DEPTH);

    logic [CW-1:0] w_count;
    logic [CW:0]   w_occ;
    logic          w_pop;
    logic          w_accept;
    logic          w_push;
    fetch_entry_t  w_push_entry;
    fetch_entry_t  w_head;

    logic          r_inflight;
    logic [31:0]   r_pc_q;
    logic          r_mis_q;
    logic          r_flt_q;

    assign rsp_valid = (w_count != '0) & ~flush;
    assign w_pop     = rsp_valid & rsp_ready;

    // A pop this cycle frees a slot immediately, which keeps DEPTH=2 at full rate.
    assign w_occ     = {1'b0, w_count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};
    assign req_ready = reset & ~flush & (w_occ < OCC_MAX);
    assign w_accept  = req_valid & req_ready;

    assign imem_en   = w_accept;
    assign imem_addr = w_accept ? req_pc[AW+1:2] : '0;

    // Request-side capture: remembers which PC the memory word now in flight belongs to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_inflight <= 1'b0;
            r_pc_q     <= '0;
            r_mis_q    <= 1'b0;
            r_flt_q    <= 1'b0;
        end else begin
            r_inflight <= w_accept;
            if (w_accept) begin
                r_pc_q  <= req_pc;
                r_mis_q <= (req_pc[1:0] != 2'b00);
                r_flt_q <= (req_pc[31:2] >= 30'(IMEM_WORDS));
            end
        end
    end

    // A redirect drops the word returning this cycle along with everything buffered.
    assign w_push                  = r_inflight & ~flush;
    assign w_push_entry.pc         = r_pc_q;
    assign w_push_entry.instr      = r_flt_q ? NOP_INSTR : imem_rdata;
    assign w_push_entry.misaligned = r_mis_q;
    assign w_push_entry.fault      = r_flt_q;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .i_clear (flush),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign rsp_pc         = w_head.pc;
    assign rsp_instr      = w_head.instr;
    assign rsp_misaligned = w_head.misaligned;
    assign rsp_fault      = w_head.fault;

endmodule
